// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - in-flight branch prediction queue with resolution, BTB training and redirect
//
// Purpose: holds fetch-time prediction records in FIFO order, compares the
// oldest one against execute's actual outcome, trains the BTB, redirects
// fetch on a misprediction and keeps saturating statistics.
//
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   fetch_valid/pc/pred_hit/pred_target, fetch_ready   prediction record push
//   res_valid/res_is_branch/res_taken/res_target       resolution of the head entry
//   update_en/update_pc/actual_target/actual_taken     BTB training (one-cycle pulse)
//   redirect_valid/redirect_pc                         fetch redirect (one-cycle pulse)
//   branch_count/mispredict_count                      saturating counters
//   underflow_err                                      sticky: resolve on empty queue
module branch_resolver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        pred_hit,
  input  logic [31:0] pred_target,
  output logic        fetch_ready,
  input  logic        res_valid,
  input  logic        res_is_branch,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        update_en,
  output logic [31:0] update_pc,
  output logic [31:0] actual_target,
  output logic        actual_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count,
  output logic        underflow_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_mem  [DEPTH];
  logic          hit_mem [DEPTH];
  logic [31:0]   tgt_mem [DEPTH];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic        update_en_q, actual_taken_q, redirect_valid_q, underflow_q;
  logic [31:0] update_pc_q, actual_target_q, redirect_pc_q;
  logic [31:0] branch_count_q, mispredict_count_q;

  logic        head_hit;
  logic [31:0] head_pc, head_tgt;
  logic        pop, push, eff_taken, mispredict;

  assign head_pc  = pc_mem[head_q];
  assign head_hit = hit_mem[head_q];
  assign head_tgt = tgt_mem[head_q];

  // Readiness looks only at current occupancy, so a push beside a pop on a
  // full queue is refused even though a slot is being freed.
  assign fetch_ready = (count_q != FULL);
  assign pop         = res_valid && (count_q != '0);
  assign eff_taken   = res_is_branch && res_taken;
  assign mispredict  = pop && ((head_hit != eff_taken) ||
                               (head_hit && eff_taken && (head_tgt != res_target)));
  // A push arriving alongside a misprediction belongs to the wrong path.
  assign push        = fetch_valid && fetch_ready && !mispredict;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispredict) begin
      // Flush: discard every younger entry and realign the pointers.
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + AW'(1);
      if (push) tail_d = tail_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]  <= fetch_pc;
      hit_mem[tail_q] <= pred_hit;
      tgt_mem[tail_q] <= pred_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      update_en_q        <= 1'b0;
      update_pc_q        <= '0;
      actual_target_q    <= '0;
      actual_taken_q     <= 1'b0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      underflow_q        <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      // Non-branches that hit in the BTB are trained as not-taken to evict them.
      update_en_q      <= pop && (res_is_branch || head_hit);
      redirect_valid_q <= mispredict;
      if (pop) begin
        update_pc_q     <= head_pc;
        actual_target_q <= res_target;
        actual_taken_q  <= eff_taken;
      end
      if (mispredict)
        redirect_pc_q <= eff_taken ? res_target : head_pc + 32'd4;
      if (pop && res_is_branch && (branch_count_q != '1))
        branch_count_q <= branch_count_q + 32'd1;
      if (mispredict && (mispredict_count_q != '1))
        mispredict_count_q <= mispredict_count_q + 32'd1;
      if (res_valid && (count_q == '0))
        underflow_q <= 1'b1;
    end
  end

  assign update_en        = update_en_q;
  assign update_pc        = update_pc_q;
  assign actual_target    = actual_target_q;
  assign actual_taken     = actual_taken_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
  assign underflow_err    = underflow_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_hit = 1'b0;
  logic [31:0] pred_target = '0;
  logic        fetch_ready;
  logic        res_valid = 1'b0;
  logic        res_is_branch = 1'b0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        update_en;
  logic [31:0] update_pc;
  logic [31:0] actual_target;
  logic        actual_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  logic        underflow_err;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] upc;
    logic [31:0] at;
    logic        atk;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];

  branch_resolver #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .pred_hit(pred_hit),
    .pred_target(pred_target), .fetch_ready(fetch_ready),
    .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
    .res_target(res_target),
    .update_en(update_en), .update_pc(update_pc), .actual_target(actual_target),
    .actual_taken(actual_taken), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .branch_count(branch_count),
    .mispredict_count(mispredict_count), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] upc, input logic [31:0] at, input logic atk,
                            input logic rv, input logic [31:0] rpc,
                            input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    e.upc = upc; e.at = at; e.atk = atk; e.rv = rv; e.rpc = rpc; e.bc = bc; e.mc = mc;
    sb.push_back(e);
  endtask

  // One clock of stimulus; returns 1 time unit after the sampling edge.
  task automatic drive(input logic fv, input logic [31:0] pc, input logic hit,
                       input logic [31:0] pt, input logic rv, input logic isb,
                       input logic tk, input logic [31:0] rt);
    fetch_valid = fv; fetch_pc = pc; pred_hit = hit; pred_target = pt;
    res_valid = rv; res_is_branch = isb; res_taken = tk; res_target = rt;
    @(posedge clk);
    #1;
    fetch_valid = 1'b0; fetch_pc = '0; pred_hit = 1'b0; pred_target = '0;
    res_valid = 1'b0; res_is_branch = 1'b0; res_taken = 1'b0; res_target = '0;
  endtask

  task automatic push(input logic [31:0] pc, input logic hit, input logic [31:0] pt);
    drive(1'b1, pc, hit, pt, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic resolve(input logic isb, input logic tk, input logic [31:0] rt);
    drive(1'b0, '0, 1'b0, '0, 1'b1, isb, tk, rt);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_fetch_ready"}, {31'b0, fetch_ready}, 32'd1);
    chk({tag, "_update_en"}, {31'b0, update_en}, 32'd0);
    chk({tag, "_update_pc"}, update_pc, 32'd0);
    chk({tag, "_actual_target"}, actual_target, 32'd0);
    chk({tag, "_actual_taken"}, {31'b0, actual_taken}, 32'd0);
    chk({tag, "_redirect_valid"}, {31'b0, redirect_valid}, 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, "_branch_count"}, branch_count, 32'd0);
    chk({tag, "_mispredict_count"}, mispredict_count, 32'd0);
    chk({tag, "_underflow_err"}, {31'b0, underflow_err}, 32'd0);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && (update_en || redirect_valid)) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got update_en=%0b redirect_valid=%0b update_pc=0x%08h expected no pulse",
                 update_en, redirect_valid, update_pc);
      end else begin
        e = sb.pop_front();
        chk("mon_update_en", {31'b0, update_en}, 32'd1);
        chk("mon_update_pc", update_pc, e.upc);
        chk("mon_actual_target", actual_target, e.at);
        chk("mon_actual_taken", {31'b0, actual_taken}, {31'b0, e.atk});
        chk("mon_redirect_valid", {31'b0, redirect_valid}, {31'b0, e.rv});
        if (e.rv) chk("mon_redirect_pc", redirect_pc, e.rpc);
        chk("mon_branch_count", branch_count, e.bc);
        chk("mon_mispredict_count", mispredict_count, e.mc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset_values("reset");
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;

    // Not-predicted taken branch: mispredict, redirect to target.
    push(32'h100, 1'b0, 32'h0);
    expect_out(32'h100, 32'h200, 1'b1, 1'b1, 32'h200, 32'd1, 32'd1);
    resolve(1'b1, 1'b1, 32'h200);
    @(posedge clk); #1;

    // Correctly predicted taken branch: train only.
    push(32'h104, 1'b1, 32'h300);
    expect_out(32'h104, 32'h300, 1'b1, 1'b0, 32'h0, 32'd2, 32'd1);
    resolve(1'b1, 1'b1, 32'h300);
    @(posedge clk); #1;

    // Predicted taken, actually not taken: redirect to pc+4.
    push(32'h108, 1'b1, 32'h400);
    expect_out(32'h108, 32'h999, 1'b0, 1'b1, 32'h10C, 32'd3, 32'd2);
    resolve(1'b1, 1'b0, 32'h999);
    @(posedge clk); #1;

    // Non-branch, no hit: silent pop.
    push(32'h10, 1'b0, 32'h0);
    resolve(1'b0, 1'b0, 32'h0);
    // Non-branch that hit: train not-taken and redirect to pc+4.
    push(32'h20, 1'b1, 32'h50);
    expect_out(32'h20, 32'h0, 1'b0, 1'b1, 32'h24, 32'd3, 32'd3);
    resolve(1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;

    // Fill the queue.
    push(32'h1000, 1'b0, 32'h0);
    push(32'h1004, 1'b0, 32'h0);
    push(32'h1008, 1'b0, 32'h0);
    push(32'h100C, 1'b0, 32'h0);
    chk("full_fetch_ready", {31'b0, fetch_ready}, 32'd0);
    push(32'h2000, 1'b0, 32'h0);
    chk("full_drop_fetch_ready", {31'b0, fetch_ready}, 32'd0);
    // Push+pop while full: push refused, occupancy drops to 3.
    expect_out(32'h1000, 32'h0, 1'b0, 1'b0, 32'h0, 32'd4, 32'd3);
    drive(1'b1, 32'h3000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("after_full_pushpop_ready", {31'b0, fetch_ready}, 32'd1);
    // Push+pop while not full: both succeed, occupancy stays 3.
    expect_out(32'h1004, 32'h0, 1'b0, 1'b0, 32'h0, 32'd5, 32'd3);
    drive(1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("pushpop_ready", {31'b0, fetch_ready}, 32'd1);
    push(32'h5000, 1'b0, 32'h0);
    chk("refill_fetch_ready", {31'b0, fetch_ready}, 32'd0);
    expect_out(32'h1008, 32'h0, 1'b0, 1'b0, 32'h0, 32'd6, 32'd3);
    resolve(1'b1, 1'b0, 32'h0);
    expect_out(32'h100C, 32'h0, 1'b0, 1'b0, 32'h0, 32'd7, 32'd3);
    resolve(1'b1, 1'b0, 32'h0);
    expect_out(32'h4000, 32'h0, 1'b0, 1'b0, 32'h0, 32'd8, 32'd3);
    resolve(1'b1, 1'b0, 32'h0);
    expect_out(32'h5000, 32'h0, 1'b0, 1'b0, 32'h0, 32'd9, 32'd3);
    resolve(1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;

    // Flush with a concurrent push.
    push(32'h6000, 1'b0, 32'h0);
    push(32'h6004, 1'b0, 32'h0);
    push(32'h6008, 1'b0, 32'h0);
    expect_out(32'h6000, 32'h7000, 1'b1, 1'b1, 32'h7000, 32'd10, 32'd4);
    drive(1'b1, 32'h6100, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h7000);
    push(32'h8000, 1'b0, 32'h0);
    expect_out(32'h8000, 32'h0, 1'b0, 1'b0, 32'h0, 32'd11, 32'd4);
    resolve(1'b1, 1'b0, 32'h0);
    chk("pre_underflow_err", {31'b0, underflow_err}, 32'd0);
    // The queue is now empty, so this resolve must only raise underflow.
    resolve(1'b1, 1'b1, 32'h1234);
    chk("underflow_err", {31'b0, underflow_err}, 32'd1);
    @(posedge clk); #1;
    chk("underflow_sticky", {31'b0, underflow_err}, 32'd1);
    chk("underflow_no_count", branch_count, 32'd11);

    // Reset mid-stream with entries in flight.
    push(32'hA000, 1'b1, 32'hB000);
    push(32'hA004, 1'b0, 32'h0);
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resolve(1'b1, 1'b1, 32'h0);
    chk("post_reset_underflow", {31'b0, underflow_err}, 32'd1);
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of in-flight prediction entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port fetch_valid, input, 1, fetch offers a prediction record this cycle.
REQ-005 The block SHALL have port fetch_pc, input, 32, PC of the fetched instruction.
REQ-006 The block SHALL have port pred_hit, input, 1, BTB hit (predicted taken) for fetch_pc.
REQ-007 The block SHALL have port pred_target, input, 32, BTB predicted target for fetch_pc.
REQ-008 The block SHALL have port fetch_ready, output, 1, queue can accept a record (not full).
REQ-009 The block SHALL have port res_valid, input, 1, execute resolves the oldest in-flight instruction.
REQ-010 The block SHALL have port res_is_branch, input, 1, resolved instruction is a branch or jump.
REQ-011 The block SHALL have port res_taken, input, 1, actual branch direction.
REQ-012 The block SHALL have port res_target, input, 32, actual branch target.
REQ-013 The block SHALL have ports update_en (1), update_pc (32), actual_target (32) and actual_taken (1), all outputs, forming the BTB training port.
REQ-014 The block SHALL have ports redirect_valid (1) and redirect_pc (32), outputs, the fetch redirect on misprediction.
REQ-015 The block SHALL have ports branch_count (32) and mispredict_count (32), outputs, saturating statistics counters.
REQ-016 The block SHALL have port underflow_err, output, 1, sticky flag set when res_valid arrives with the queue empty.

Function
REQ-017 Push: when fetch_valid && fetch_ready, the block SHALL store {fetch_pc, pred_hit, pred_target} at the tail in FIFO order.
REQ-018 Pop: when res_valid and the queue is non-empty, the block SHALL consume the head entry in the same cycle.
REQ-019 Simultaneous push and pop on a full queue SHALL be rejected for the push, because fetch_ready depends only on the current occupancy.
REQ-020 Simultaneous push and pop on a non-full queue SHALL both succeed, leaving occupancy unchanged.
REQ-021 Misprediction SHALL be computed as (head.hit != eff_taken) || (head.hit && eff_taken && head.target != res_target), where eff_taken = res_is_branch && res_taken.
REQ-022 On a pop with res_is_branch=1, the block SHALL, in the next cycle only, assert update_en=1, update_pc=head.pc, actual_target=res_target and actual_taken=res_taken.
REQ-023 On a pop with res_is_branch=0 and head.hit=1, the block SHALL assert update_en for one cycle with actual_taken=0.
REQ-024 On a pop with res_is_branch=0 and head.hit=0, update_en SHALL stay 0.
REQ-025 On a mispredicted pop, the block SHALL assert redirect_valid for exactly one cycle, in the next cycle.
REQ-026 On that redirect, redirect_pc SHALL be res_target when eff_taken=1, else head.pc+4 (modulo 2^32).
REQ-027 On a mispredicted pop, the block SHALL flush all remaining entries (occupancy becomes 0) at the same edge.
REQ-028 Any push presented in the mispredicted cycle SHALL be discarded.
REQ-029 branch_count SHALL increment on every pop with res_is_branch=1, saturating at 0xFFFFFFFF.
REQ-030 mispredict_count SHALL increment on every mispredicted pop, saturating at 0xFFFFFFFF.
REQ-031 res_valid with an empty queue SHALL be ignored except for setting underflow_err, which SHALL remain set until reset.
REQ-032 The FIFO head and tail pointers SHALL wrap modulo DEPTH.
REQ-033 Full and empty SHALL be distinguished by an occupancy count of width log2(DEPTH)+1.

Reset
REQ-034 While reset=0, the block SHALL asynchronously clear occupancy, the head and tail pointers, update_en, redirect_valid, both counters and underflow_err.
REQ-035 While reset=0, update_pc, actual_target, actual_taken and redirect_pc SHALL be 0.
REQ-036 While reset=0, fetch_ready SHALL be 1.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight entries with no update_en or redirect_valid pulse afterwards.

Verification
REQ-038 The bench SHALL cover: push pc=0x100, hit=0, then resolve is_branch=1, taken=1, target=0x200 -> next cycle update_en=1, update_pc=0x100, actual_target=0x200, redirect_valid=1, redirect_pc=0x200, mispredict_count=1.
REQ-039 The bench SHALL cover: push pc=0x104, hit=1, target=0x300, then resolve taken=1, target=0x300 -> update_en=1, redirect_valid=0, branch_count increments.
REQ-040 The bench SHALL cover: push pc=0x108, hit=1, then resolve taken=0 -> redirect_pc=0x10C and actual_taken=0.
REQ-041 The bench SHALL cover: push DEPTH entries -> fetch_ready=0, and a further push is dropped; then push and pop in the same cycle -> occupancy is unchanged from DEPTH-1.
REQ-042 The bench SHALL cover: 3 entries queued and the head mispredicts while fetch_valid=1 -> occupancy becomes 0 and the concurrent push is lost.
REQ-043 The bench SHALL cover: res_valid on an empty queue -> underflow_err=1 (sticky) and no update_en; then assert reset=0 mid-stream -> all outputs reach reset values.
